// File: rtl/ha_array_accum_seq.sv
// Sequencer for the approximate 8x8 multiplier HA-array stage: latches operands, weights and sums four array rows, saturates.
// Optional compile-time feature HA_ACC_COMP_EN adds COMP_BIAS to the final sum before saturation.
module ha_array_accum_seq #(
    parameter int          ACC_W     = 17,
    parameter logic [15:0] COMP_BIAS = 16'd32
) (
    input  logic        clk,
    input  logic        rst,
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds data stable while valid is high and ready is low.
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  arr_x,
    output logic [7:0]  arr_y,
    input  logic [27:0] row_b,
    input  logic [35:0] row_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_row;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_arr_x;
    logic [7:0]       r_arr_y;
    logic [15:0]      r_out_p;

    logic [6:0]       w_b;
    logic [8:0]       w_t;
    logic [9:0]       w_row_base;
    logic [ACC_W-1:0] w_row_term;
    logic [ACC_W-1:0] w_acc_sum;
    logic [ACC_W-1:0] w_acc_final;
    logic [15:0]      w_sat;
    logic             w_zero_op;

    always_comb begin
        w_b = 7'd0;
        w_t = 9'd0;
        case (r_row)
            2'd0: begin w_b = row_b[6:0];   w_t = row_t[8:0];   end
            2'd1: begin w_b = row_b[13:7];  w_t = row_t[17:9];  end
            2'd2: begin w_b = row_b[20:14]; w_t = row_t[26:18]; end
            default: begin w_b = row_b[27:21]; w_t = row_t[35:27]; end
        endcase
    end

    // Row weight: t + 4*b, shifted left by two bits per row index.
    assign w_row_base = {1'b0, w_t} + {1'b0, w_b, 2'b00};
    assign w_row_term = ACC_W'(w_row_base) << {r_row, 1'b0};
    assign w_acc_sum  = r_acc + w_row_term;

`ifdef HA_ACC_COMP_EN
    assign w_acc_final = w_acc_sum + ACC_W'(COMP_BIAS);
`else
    assign w_acc_final = w_acc_sum;
`endif

    assign w_sat     = (w_acc_final > ACC_W'(16'hFFFF)) ? 16'hFFFF : w_acc_final[15:0];
    assign w_zero_op = (in_x == 8'd0) || (in_y == 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = w_zero_op ? ST_DONE : ST_ACC;
            ST_ACC:  if (r_row == 2'd3) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_row   <= 2'd0;
            r_acc   <= '0;
            r_arr_x <= 8'd0;
            r_arr_y <= 8'd0;
            r_out_p <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_arr_x <= in_x;
                        r_arr_y <= in_y;
                        r_acc   <= '0;
                        r_row   <= 2'd0;
                        if (w_zero_op) r_out_p <= 16'd0;
                    end
                end
                ST_ACC: begin
                    r_row <= r_row + 2'd1;
                    // The last row carries the optional bias and latches the saturated result.
                    if (r_row == 2'd3) begin
                        r_acc   <= w_acc_final;
                        r_out_p <= w_sat;
                    end else begin
                        r_acc <= w_acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;
    assign arr_x     = r_arr_x;
    assign arr_y     = r_arr_y;
    assign out_p     = r_out_p;

endmodule

// File: tb/tb_ha_array_accum_seq.sv
// Directed bench for ha_array_accum_seq; row vectors come from a stub array with hand-computed sums.
module tb_ha_array_accum_seq;

    localparam int COMP_BIAS_TB = 32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [7:0]  arr_x;
    logic [7:0]  arr_y;
    logic [27:0] row_b;
    logic [35:0] row_t;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q[$];

    ha_array_accum_seq #(.ACC_W(17), .COMP_BIAS(16'd32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .arr_x     (arr_x),
        .arr_y     (arr_y),
        .row_b     (row_b),
        .row_t     (row_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Expected product for a non-bypass operation given the hand-computed row sum.
    function automatic logic [15:0] exp_np(input int base);
        int v;
        v = base;
`ifdef HA_ACC_COMP_EN
        v = v + COMP_BIAS_TB;
`endif
        if (v > 65535) return 16'hFFFF;
        return v[15:0];
    endfunction

    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [27:0] b, input logic [35:0] t,
                          input logic [15:0] exp_p, input int exp_lat, input int hold);
        int lat;
        logic [15:0] want;
        row_b = b;
        row_t = t;
        exp_q.push_back(exp_p);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        check("arr_x_latched", arr_x, x);
        check("arr_y_latched", arr_y, y);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, exp_lat);
        want = exp_q.pop_front();
        check("out_p", out_p, want);
        check("busy_done", busy, 1);
        check("in_ready_done", in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            in_x     = 8'hA5 ^ 8'(k);
            in_y     = 8'h3C + 8'(k);
            @(posedge clk);
            @(negedge clk);
            check("hold_out_p", out_p, want);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_arr_x", arr_x, x);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_busy", busy, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = 8'd0;
        in_y      = 8'd0;
        row_b     = '0;
        row_t     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_p", out_p, 0);
        check("rst_arr_x", arr_x, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // Zero bypass: rows are ignored, no bias applied.
        run_op(8'd0, 8'd5, {28{1'b1}}, {36{1'b1}}, 16'd0, 1, 0);
        run_op(8'd7, 8'd0, {28{1'b1}}, {36{1'b1}}, 16'd0, 1, 0);
        // 1x1: array yields t0=1.
        run_op(8'd1, 8'd1, 28'd0, {9'd0, 9'd0, 9'd0, 9'd1}, exp_np(1), 5, 0);
        // 2x3: array drops y0x1, leaving b0=1 -> 4.
        run_op(8'd2, 8'd3, {7'd0, 7'd0, 7'd0, 7'd1}, 36'd0, exp_np(4), 5, 0);
        // Mixed rows: 0 + 36 + 32 + 448 = 516.
        run_op(8'd9, 8'd11, {7'd1, 7'd0, 7'd2, 7'd0}, {9'd3, 9'd2, 9'd1, 9'd0}, exp_np(516), 5, 0);
        // Exactly 0xFFFF: 1019*64 + 319.
        run_op(8'd200, 8'd201, {7'd127, 21'd0}, {9'd511, 18'd0, 9'd319}, exp_np(65535), 5, 0);
        // All ones: 1019*85 = 86615, saturates; hold in DONE for 10 cycles.
        run_op(8'hFF, 8'hFF, {28{1'b1}}, {36{1'b1}}, exp_np(86615), 5, 10);

        // Asynchronous reset while row 2 is being accumulated.
        row_b = {7'd1, 7'd0, 7'd2, 7'd0};
        row_t = {9'd3, 9'd2, 9'd1, 9'd0};
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 8'd9;
        in_y     = 8'd11;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_arr_x", arr_x, 0);
        check("midrst_out_p", out_p, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd1, 8'd1, 28'd0, {9'd0, 9'd0, 9'd0, 9'd1}, exp_np(1), 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
